// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared state type and parameter limits for the FIFO push arbiter
package fifo_arb_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_LOCK = 1'b1
   } arb_state_t;

   localparam int NUM_REQ_MIN    = 2;
   localparam int NUM_REQ_MAX    = 16;
   localparam int DATA_WIDTH_MIN = 1;
   localparam int MAX_BURST_MIN  = 1;
   localparam int MAX_BURST_MAX  = 256;

endpackage

// File: rtl/rr_prio_sel.sv
// rtl/rr_prio_sel.sv - round-robin search: first valid requester at or after the pointer
module rr_prio_sel
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_valid,
   input  logic [IDX_W-1:0]   i_ptr,
   output logic [IDX_W-1:0]   o_idx,
   output logic               o_found
);

   logic [IDX_W:0] w_cand;

   // Walk offsets from farthest to nearest so the nearest valid requester wins.
   always_comb begin
      o_idx   = i_ptr;
      o_found = 1'b0;
      w_cand  = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         w_cand = {1'b0, i_ptr} + (IDX_W+1)'(i);
         if (w_cand >= (IDX_W+1)'(NUM_REQ)) begin
            w_cand = w_cand - (IDX_W+1)'(NUM_REQ);
         end
         if (i_valid[w_cand[IDX_W-1:0]]) begin
            o_idx   = w_cand[IDX_W-1:0];
            o_found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_push_arbiter.sv
// rtl/fifo_push_arbiter.sv - round-robin, burst-locking arbiter in front of a shared FIFO push port
module fifo_push_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_BURST  = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          clear_i,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
   input  logic [NUM_REQ-1:0]            req_last_i,
   output logic [NUM_REQ-1:0]            req_grant_o,
   output logic [DATA_WIDTH-1:0]         fifo_data_o,
   output logic                          fifo_valid_o,
   input  logic                          fifo_grant_i,
   output logic [$clog2(NUM_REQ)-1:0]    gnt_id_o,
   output logic                          lock_o
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_BURST + 1);

   arb_state_t         r_state;
   arb_state_t         w_state_nxt;
   logic [IDX_W-1:0]   r_rr_ptr;
   logic [IDX_W-1:0]   w_rr_ptr_nxt;
   logic [IDX_W-1:0]   r_owner;
   logic [IDX_W-1:0]   w_owner_nxt;
   logic [CNT_W-1:0]   r_burst_cnt;
   logic [CNT_W-1:0]   w_burst_cnt_nxt;

   logic [IDX_W-1:0]   w_rr_idx;
   logic               w_rr_found;
   logic [IDX_W-1:0]   w_sel;
   logic [IDX_W-1:0]   w_sel_inc;
   logic               w_sel_valid;
   logic               w_sel_last;
   logic               w_xfer;
   logic               w_burst_end;

   rr_prio_sel #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_prio_sel (
      .i_valid (req_valid_i),
      .i_ptr   (r_rr_ptr),
      .o_idx   (w_rr_idx),
      .o_found (w_rr_found)
   );

   // Selection is forced to requester 0 while reset is held so the push port stays well defined.
   always_comb begin
      if (!rst_n) begin
         w_sel = '0;
      end else if (r_state == ST_LOCK) begin
         w_sel = r_owner;
      end else if (w_rr_found) begin
         w_sel = w_rr_idx;
      end else begin
         w_sel = r_rr_ptr;
      end
   end

   assign w_sel_valid = req_valid_i[w_sel];
   assign w_sel_last  = req_last_i[w_sel];
   assign w_sel_inc   = (w_sel == IDX_W'(NUM_REQ - 1)) ? '0 : w_sel + IDX_W'(1);
   assign w_burst_end = (r_burst_cnt == CNT_W'(MAX_BURST - 1));

   assign fifo_valid_o = w_sel_valid & ~clear_i;
   assign fifo_data_o  = req_data_i[w_sel*DATA_WIDTH +: DATA_WIDTH];
   assign w_xfer       = fifo_valid_o & fifo_grant_i & rst_n;
   assign gnt_id_o     = w_sel;
   assign lock_o       = (r_state == ST_LOCK);

   always_comb begin
      req_grant_o = '0;
      if (w_xfer) begin
         req_grant_o[w_sel] = 1'b1;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_rr_ptr_nxt    = r_rr_ptr;
      w_owner_nxt     = r_owner;
      w_burst_cnt_nxt = r_burst_cnt;
      if (clear_i) begin
         w_state_nxt     = ST_IDLE;
         w_rr_ptr_nxt    = '0;
         w_owner_nxt     = '0;
         w_burst_cnt_nxt = '0;
      end else if (w_xfer) begin
         case (r_state)
            ST_IDLE: begin
               if (w_sel_last || (MAX_BURST == 1)) begin
                  w_rr_ptr_nxt    = w_sel_inc;
                  w_burst_cnt_nxt = '0;
               end else begin
                  w_state_nxt     = ST_LOCK;
                  w_owner_nxt     = w_sel;
                  w_burst_cnt_nxt = CNT_W'(1);
               end
            end
            ST_LOCK: begin
               if (w_sel_last || w_burst_end) begin
                  w_state_nxt     = ST_IDLE;
                  w_rr_ptr_nxt    = w_sel_inc;
                  w_burst_cnt_nxt = '0;
               end else begin
                  w_burst_cnt_nxt = r_burst_cnt + CNT_W'(1);
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_rr_ptr    <= '0;
         r_owner     <= '0;
         r_burst_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_rr_ptr    <= w_rr_ptr_nxt;
         r_owner     <= w_owner_nxt;
         r_burst_cnt <= w_burst_cnt_nxt;
      end
   end

endmodule
